aes_seq_ctrl: RTL and testbench

Transaction sequencer between the verification platform and the AES-128 chip. It accepts one 128-bit job (key, text, expected result, direction) and serialises it to the chip as 32 paced byte strobes on the 9-bit `aes_tx` link. It then collects 16 result bytes from `aes_rx`, compares them against the expected block and updates the running `total`/`correct` counters. It replaces the free-running pattern driver inside the platform top and runs in the platform clock domain.

---
 rtl/aes_plat_pkg.sv | 20 ++
 rtl/aes_seq_ctrl_if.sv | 24 ++
 rtl/aes_byte_pacer.sv | 25 ++
 rtl/aes_seq_ctrl.sv | 139 +++++++++++++
 tb/tb_aes_seq_ctrl.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_plat_pkg.sv
// Shared definitions for the AES platform sequencer: FSM encoding, byte counts,
// link field positions and a saturating counter helper.
package aes_plat_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_RECV  = 2'd2,
        ST_CHECK = 2'd3
    } state_t;

    localparam int TX_BYTES = 32;
    localparam int RX_BYTES = 16;
    localparam int LINK_STB = 8;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/aes_seq_ctrl_if.sv
// Job-side handshake between the platform and the AES sequencer.
interface aes_seq_ctrl_if;
    logic         start;
    logic         enc;
    logic [127:0] key;
    logic [127:0] din;
    logic [127:0] expected;
    logic         busy;
    logic         done;
    logic         pass;
    logic         timeout;
    logic [31:0]  total;
    logic [31:0]  correct;

    modport master (
        output start, enc, key, din, expected,
        input  busy, done, pass, timeout, total, correct
    );

    modport slave (
        input  start, enc, key, din, expected,
        output busy, done, pass, timeout, total, correct
    );
endinterface

// File: rtl/aes_byte_pacer.sv
// Byte slot timer: BYTE_DIV-cycle slots, strobe high for the first half,
// slot_end on the last cycle. Cleared synchronously when a job is accepted.
module aes_byte_pacer #(
    parameter int BYTE_DIV = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic stb,
    output logic slot_end
);
    localparam int CW = (BYTE_DIV > 1) ? $clog2(BYTE_DIV) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              cnt <= '0;
        else if (clr || slot_end) cnt <= '0;
        else if (en)             cnt <= cnt + CW'(1);
    end

    assign stb      = en && (cnt < CW'(BYTE_DIV / 2));
    assign slot_end = en && (cnt == CW'(BYTE_DIV - 1));
endmodule

// File: rtl/aes_seq_ctrl.sv
// AES chip transaction sequencer: serialises key+text as paced byte strobes,
// collects 16 result bytes, compares against the expected block and counts.
module aes_seq_ctrl
    import aes_plat_pkg::*;
#(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int BYTE_FREQ   = 50_000,
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic               clk,
    input  logic               rst_n,
    aes_seq_ctrl_if.slave      job,
    output logic               chip_enc,
    output logic [8:0]         aes_tx,
    input  logic [8:0]         aes_rx
);
    localparam int BYTE_DIV = CLK_FREQ / BYTE_FREQ;
    localparam int TW       = $clog2(TIMEOUT_CYC + 1);

    state_t         state, state_nx;
    logic [255:0]   tx_sh;
    logic [4:0]     tx_idx;
    logic [127:0]   rx_sh, exp_q, rx_blk_nx;
    logic [3:0]     rx_idx;
    logic [TW-1:0]  tcnt;
    logic [8:0]     rx_s1, rx_s2;
    logic           rx_stb_d;
    logic           pass_q, timeout_q;
    logic [31:0]    total_q, correct_q;
    logic           accept, stb, slot_end;
    logic           rx_edge, to_fire, rx_cap, rx_last, blk_match;

    aes_byte_pacer #(.BYTE_DIV(BYTE_DIV)) u_pacer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (accept),
        .en       (state == ST_SEND),
        .stb      (stb),
        .slot_end (slot_end)
    );

    // Timeout wins over a strobe edge arriving in the same cycle.
    assign rx_edge   = rx_s2[LINK_STB] & ~rx_stb_d;
    assign to_fire   = (state == ST_RECV) && (tcnt == TW'(TIMEOUT_CYC - 1));
    assign rx_cap    = (state == ST_RECV) && rx_edge && !to_fire;
    assign rx_last   = rx_cap && (rx_idx == 4'(RX_BYTES - 1));
    assign rx_blk_nx = {rx_sh[119:0], rx_s2[7:0]};
    assign blk_match = (rx_blk_nx == exp_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        unique case (state)
            ST_IDLE: if (job.start) begin
                accept   = 1'b1;
                state_nx = ST_SEND;
            end
            ST_SEND:  if (slot_end && tx_idx == 5'(TX_BYTES - 1)) state_nx = ST_RECV;
            ST_RECV:  if (to_fire || rx_last) state_nx = ST_CHECK;
            ST_CHECK: state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        aes_tx = 9'h000;
        if (state == ST_SEND) begin
            aes_tx[7:0]      = tx_sh[255:248];
            aes_tx[LINK_STB] = stb;
        end
    end

    // Result flags and counters are written on the edge into CHECK so they
    // line up with the done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_sh     <= '0;
            tx_idx    <= '0;
            exp_q     <= '0;
            chip_enc  <= 1'b0;
            rx_sh     <= '0;
            rx_idx    <= '0;
            tcnt      <= '0;
            rx_s1     <= '0;
            rx_s2     <= '0;
            rx_stb_d  <= 1'b0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
            total_q   <= '0;
            correct_q <= '0;
        end else begin
            rx_s1    <= aes_rx;
            rx_s2    <= rx_s1;
            rx_stb_d <= rx_s2[LINK_STB];

            if (accept) begin
                tx_sh     <= {job.key, job.din};
                exp_q     <= job.expected;
                chip_enc  <= job.enc;
                tx_idx    <= '0;
                pass_q    <= 1'b0;
                timeout_q <= 1'b0;
            end else if (state == ST_SEND && slot_end) begin
                tx_sh  <= {tx_sh[247:0], 8'h00};
                tx_idx <= tx_idx + 5'd1;
            end

            if (state != ST_RECV) begin
                tcnt   <= '0;
                rx_idx <= '0;
            end else if (rx_cap) begin
                rx_sh  <= rx_blk_nx;
                rx_idx <= rx_idx + 4'd1;
                tcnt   <= '0;
            end else begin
                tcnt <= tcnt + TW'(1);
            end

            if (rx_last || to_fire) begin
                pass_q    <= rx_last && blk_match;
                timeout_q <= to_fire;
                total_q   <= sat_inc(total_q);
                if (rx_last && blk_match) correct_q <= sat_inc(correct_q);
            end
        end
    end

    assign job.busy    = (state != ST_IDLE);
    assign job.done    = (state == ST_CHECK);
    assign job.pass    = pass_q;
    assign job.timeout = timeout_q;
    assign job.total   = total_q;
    assign job.correct = correct_q;
endmodule

// File: tb/tb_aes_seq_ctrl.sv
// Directed bench for aes_seq_ctrl: a cycle-level model of the job protocol
// plus a simple chip responder; outputs are compared on every falling edge.
module tb_aes_seq_ctrl;
    localparam int CLK_FREQ    = 16;
    localparam int BYTE_FREQ   = 1;
    localparam int TIMEOUT_CYC = 100;
    localparam int BD          = CLK_FREQ / BYTE_FREQ;

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] D1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] E1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       chip_enc;
    logic [8:0] aes_tx;
    logic [8:0] aes_rx = 9'h000;

    aes_seq_ctrl_if job ();

    aes_seq_ctrl #(
        .CLK_FREQ    (CLK_FREQ),
        .BYTE_FREQ   (BYTE_FREQ),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .job      (job),
        .chip_enc (chip_enc),
        .aes_tx   (aes_tx),
        .aes_rx   (aes_rx)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // model state
    bit           in_job;
    int           t0;
    logic [7:0]   m_stream [32];
    logic [127:0] m_exp;
    logic         m_enc, m_pass, m_to;
    bit           m_valid;
    logic [31:0]  m_total, m_correct;
    int           n_send;
    logic [127:0] sent_blk;
    int           rises [$];
    int           done_cnt;
    int           done_cyc;
    logic [7:0]   txlog [32];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cyc %0d: got %h want %h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] sinc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic int predict_done();
        if (n_send > 0 && rises.size() == n_send)
            return rises[n_send-1] + 3 + ((n_send < 16) ? TIMEOUT_CYC : 0);
        return -1;
    endfunction

    always @(negedge clk) begin
        int k, tdone;
        bit was_busy, edone, ebusy;
        logic [8:0] etx;
        if (rst_n) begin
            was_busy = in_job;
            k     = in_job ? cyc - t0 : 0;
            tdone = predict_done();
            etx   = 9'h000;
            if (in_job && k >= 1 && k <= 32*BD) begin
                etx = {(((k-1) % BD) < BD/2) ? 1'b1 : 1'b0, m_stream[(k-1)/BD]};
                if ((k-1) % BD == 0) txlog[(k-1)/BD] = aes_tx[7:0];
            end
            edone = in_job && tdone >= 0 && cyc == tdone;
            ebusy = in_job && k >= 1;
            if (edone) begin
                m_total = sinc(m_total);
                m_pass  = (n_send == 16) && (sent_blk == m_exp);
                m_to    = (n_send < 16);
                if (m_pass) m_correct = sinc(m_correct);
                m_valid  = 1'b1;
                done_cyc = cyc;
            end
            chk("aes_tx", 128'(aes_tx), 128'(etx));
            chk("busy", 128'(job.busy), 128'(ebusy));
            chk("done", 128'(job.done), 128'(edone));
            chk("total", 128'(job.total), 128'(m_total));
            chk("correct", 128'(job.correct), 128'(m_correct));
            chk("chip_enc", 128'(chip_enc), 128'(m_enc));
            if (m_valid) begin
                chk("pass", 128'(job.pass), 128'(m_pass));
                chk("timeout", 128'(job.timeout), 128'(m_to));
            end
            if (job.done) done_cnt++;
            if (edone) in_job = 1'b0;
            if (!was_busy && job.start) begin
                in_job  = 1'b1;
                t0      = cyc;
                m_exp   = job.expected;
                m_enc   = job.enc;
                m_valid = 1'b0;
                for (int i = 0; i < 16; i++) begin
                    m_stream[i]    = job.key[127-8*i -: 8];
                    m_stream[16+i] = job.din[127-8*i -: 8];
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic to_cyc(input int c);
        while (cyc < c) step(1);
    endtask

    task automatic start_job(input logic [127:0] k, input logic [127:0] d, input logic [127:0] e,
                             input logic en, input int nsend, input bit flip, output int a0);
        n_send   = nsend;
        sent_blk = e;
        if (flip) sent_blk[0] = ~sent_blk[0];
        rises.delete();
        for (int i = 0; i < 32; i++) txlog[i] = 8'hxx;
        job.key      = k;
        job.din      = d;
        job.expected = e;
        job.enc      = en;
        job.start    = 1'b1;
        a0 = cyc;
        step(1);
        job.start = 1'b0;
    endtask

    task automatic chip_respond(input int a0, input bit mid_start);
        if (mid_start) begin
            to_cyc(a0 + 16*BD);
            job.key   = 128'hdeadbeef_cafef00d_01234567_89abcdef;
            job.start = 1'b1;
            step(1);
            job.start = 1'b0;
        end
        to_cyc(a0 + 32*BD + 8);
        for (int i = 0; i < n_send; i++) begin
            aes_rx = {1'b1, sent_blk[127-8*i -: 8]};
            rises.push_back(cyc);
            step(4);
            aes_rx[8] = 1'b0;
            step(4);
        end
    endtask

    task automatic wait_done(input int dc0);
        int w;
        w = 0;
        while (done_cnt == dc0 && w < 2000) begin
            step(1);
            w++;
        end
        step(3);
        chk("done_count", 128'(done_cnt - dc0), 128'(1));
    endtask

    task automatic run_job(input logic [127:0] k, input logic [127:0] d, input logic [127:0] e,
                           input logic en, input int nsend, input bit flip, input bit mid);
        int a0, dc0;
        dc0 = done_cnt;
        start_job(k, d, e, en, nsend, flip, a0);
        chip_respond(a0, mid);
        wait_done(dc0);
    endtask

    initial begin
        int a0;
        in_job = 0; m_enc = 0; m_pass = 0; m_to = 0; m_valid = 1;
        m_total = 0; m_correct = 0; done_cnt = 0; n_send = 0;
        job.start = 1'b0; job.enc = 1'b0;
        job.key = '0; job.din = '0; job.expected = '0;

        step(3);
        chk("rst_aes_tx", 128'(aes_tx), 128'(9'h000));
        chk("rst_busy", 128'(job.busy), 128'(0));
        chk("rst_done", 128'(job.done), 128'(0));
        chk("rst_total", 128'(job.total), 128'(0));
        chk("rst_correct", 128'(job.correct), 128'(0));
        rst_n = 1'b1;
        step(2);

        // encrypt, chip echoes expected block
        run_job(K1, D1, E1, 1'b1, 16, 1'b0, 1'b0);
        chk("enc_pass", 128'(job.pass), 128'(1));
        chk("enc_total", 128'(job.total), 128'(1));
        chk("enc_correct", 128'(job.correct), 128'(1));
        chk("tx_first", 128'(txlog[0]), 128'(8'h00));
        chk("tx_key_last", 128'(txlog[15]), 128'(8'h0f));
        chk("tx_din_1", 128'(txlog[17]), 128'(8'h11));
        chk("tx_last", 128'(txlog[31]), 128'(8'hff));

        // byte 15 LSB flipped
        run_job(K1, D1, E1, 1'b0, 16, 1'b1, 1'b0);
        chk("mis_pass", 128'(job.pass), 128'(0));
        chk("mis_timeout", 128'(job.timeout), 128'(0));
        chk("mis_total", 128'(job.total), 128'(2));
        chk("mis_correct", 128'(job.correct), 128'(1));

        // only 5 bytes returned
        run_job(K1, D1, E1, 1'b1, 5, 1'b0, 1'b0);
        chk("to_timeout", 128'(job.timeout), 128'(1));
        chk("to_pass", 128'(job.pass), 128'(0));
        chk("to_total", 128'(job.total), 128'(3));
        chk("to_correct", 128'(job.correct), 128'(1));
        chk("to_latency", 128'(done_cyc - rises[4]), 128'(103));

        // start mid-SEND must be ignored
        run_job(K1, D1, E1, 1'b1, 16, 1'b0, 1'b1);
        chk("bsy_total", 128'(job.total), 128'(4));
        chk("bsy_correct", 128'(job.correct), 128'(2));

        // reset during byte 10 of SEND
        start_job(K1, D1, E1, 1'b1, 16, 1'b0, a0);
        to_cyc(a0 + 10*BD + 4);
        rst_n = 1'b0;
        in_job = 0; m_total = 0; m_correct = 0; m_pass = 0; m_to = 0; m_valid = 1; m_enc = 0;
        #1;
        chk("mrst_aes_tx", 128'(aes_tx), 128'(9'h000));
        chk("mrst_busy", 128'(job.busy), 128'(0));
        chk("mrst_total", 128'(job.total), 128'(0));
        chk("mrst_correct", 128'(job.correct), 128'(0));
        step(2);
        rst_n = 1'b1;
        step(2);
        run_job({8'ha5, K1[119:0]}, D1, E1, 1'b1, 16, 1'b0, 1'b0);
        chk("post_rst_first", 128'(txlog[0]), 128'(8'ha5));
        chk("post_rst_total", 128'(job.total), 128'(1));

        // saturation
        force dut.total_q = 32'hFFFF_FFFF;
        force dut.correct_q = 32'hFFFF_FFFF;
        m_total = 32'hFFFF_FFFF;
        m_correct = 32'hFFFF_FFFF;
        step(1);
        release dut.total_q;
        release dut.correct_q;
        step(1);
        run_job(K1, D1, E1, 1'b1, 16, 1'b0, 1'b0);
        chk("sat_pass", 128'(job.pass), 128'(1));
        chk("sat_total", 128'(job.total), 128'(32'hFFFF_FFFF));
        chk("sat_correct", 128'(job.correct), 128'(32'hFFFF_FFFF));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
